// File: rtl/decoder_3x8_seq.sv
// Registered 3-to-8 one-hot decoder with a minimum output hold time and release counter.
// Latency: one edge from accept to out_valid; out_valid stays up at least HOLD_CYCLES cycles.
// Backpressure: out_ready is honoured only after the hold expires; in_ready is low while a decode is in flight.
module decoder_3x8_seq #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] decode_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Counter is loaded with HOLD_CYCLES-1 because the accept edge itself
  // already accounts for the first cycle of out_valid.
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam bit         SKIP_HOLD = (HOLD_CYCLES == 1);

  state_t     state;
  logic [7:0] hold_cnt;

  // Only the accept qualifier is combinational; new codes are taken in IDLE when enabled.
  assign in_ready = (state == IDLE) && en;

  // Decode FSM: capture code on accept, enforce the minimum hold, then wait for the downstream ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      hold_cnt     <= 8'd0;
      out          <= 8'h00;
      out_valid    <= 1'b0;
      decode_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            out       <= 8'h01 << in;
            out_valid <= 1'b1;
            hold_cnt  <= HOLD_LOAD;
            state     <= SKIP_HOLD ? DRAIN : HOLD;
          end
        end
        HOLD: begin
          // out_ready is deliberately ignored here so the hold cannot be cut short.
          hold_cnt <= hold_cnt - 8'd1;
          if (hold_cnt == 8'd1) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            out          <= 8'h00;
            out_valid    <= 1'b0;
            decode_count <= decode_count + 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out       <= 8'h00;
          out_valid <= 1'b0;
          hold_cnt  <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_3x8_seq.sv
// Bench for decoder_3x8_seq: two instances (HOLD=4/CNT_W=8 and HOLD=1/CNT_W=3)
// compared every cycle against a transaction-level model, plus directed checks.
module tb_decoder_3x8_seq;

  logic       clk;
  logic       rst_n;
  logic       en    [2];
  logic [2:0] code  [2];
  logic       ivld  [2];
  logic       ordy  [2];

  logic       ir0, ir1, ov0, ov1;
  logic [7:0] out0, out1;
  logic [7:0] cnt0;
  logic [2:0] cnt1;

  int total = 0;
  int bad   = 0;

  // Model: a decode is "busy" from its accept edge until its release edge.
  // Release happens at an edge where out_valid has already been up for at
  // least HOLD cycles and the downstream acknowledges.
  int       hold_p [2] = '{4, 1};
  int       cmod   [2] = '{256, 8};
  bit       m_busy [2];
  int       m_code [2];
  int       m_age  [2];
  int       m_cnt  [2];

  decoder_3x8_seq #(.HOLD_CYCLES(4), .CNT_W(8)) d0 (
    .clk(clk), .rst_n(rst_n), .en(en[0]), .in(code[0]), .in_valid(ivld[0]),
    .in_ready(ir0), .out(out0), .out_valid(ov0), .out_ready(ordy[0]),
    .decode_count(cnt0)
  );

  decoder_3x8_seq #(.HOLD_CYCLES(1), .CNT_W(3)) d1 (
    .clk(clk), .rst_n(rst_n), .en(en[1]), .in(code[1]), .in_valid(ivld[1]),
    .in_ready(ir1), .out(out1), .out_valid(ov1), .out_ready(ordy[1]),
    .decode_count(cnt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_inst(input int i, input logic [7:0] o, input logic ov,
                            input logic ir, input logic [31:0] cnt);
    logic [7:0] exp_out;
    exp_out = m_busy[i] ? (8'h01 << m_code[i]) : 8'h00;
    chk($sformatf("d%0d_out", i), 32'(o), 32'(exp_out));
    chk($sformatf("d%0d_out_valid", i), 32'(ov), 32'(m_busy[i]));
    chk($sformatf("d%0d_in_ready", i), 32'(ir), 32'(!m_busy[i] && en[i]));
    chk($sformatf("d%0d_count", i), cnt, 32'(m_cnt[i]));
  endtask

  task automatic model_edge(input int i);
    if (!rst_n) begin
      m_busy[i] = 1'b0;
      m_age[i]  = 0;
      m_cnt[i]  = 0;
    end else if (m_busy[i]) begin
      m_age[i]++;
      if (m_age[i] >= hold_p[i] && ordy[i]) begin
        m_busy[i] = 1'b0;
        m_cnt[i]  = (m_cnt[i] + 1) % cmod[i];
      end
    end else if (en[i] && ivld[i]) begin
      m_busy[i] = 1'b1;
      m_code[i] = int'(code[i]);
      m_age[i]  = 0;
    end
  endtask

  // One cycle: inputs already set at the negedge; check, advance model, clock.
  task automatic step();
    #1;
    check_inst(0, out0, ov0, ir0, 32'(cnt0));
    check_inst(1, out1, ov1, ir1, 32'(cnt1));
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b0; code[i] = 3'd0; ivld[i] = 1'b0; ordy[i] = 1'b1;
      m_busy[i] = 1'b0; m_code[i] = 0; m_age[i] = 0; m_cnt[i] = 0;
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    step();
    rst_n = 1'b1;

    // Codes 0..7 through d0; code changes right after accept must not leak through.
    en[0] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      code[0] = 3'(c); ivld[0] = 1'b1;
      step();
      ivld[0] = 1'b0;
      code[0] = 3'($urandom_range(0, 7));
      step();
      chk("captured_code", 32'(out0), 32'(8'h01 << c));
      step(); step(); step();
    end
    chk("count_after_8", 32'(cnt0), 32'd8);

    // Backpressure: code 5 held well past the hold time.
    code[0] = 3'd5; ivld[0] = 1'b1; ordy[0] = 1'b0;
    step();
    ivld[0] = 1'b0;
    for (int k = 0; k < 10; k++) step();
    chk("bp_out_held", 32'(out0), 32'h20);
    chk("bp_in_ready_low", 32'(ir0), 32'd0);
    ordy[0] = 1'b1;
    step();
    chk("bp_released", 32'(ov0), 32'd0);
    chk("bp_count", 32'(cnt0), 32'd9);
    step();

    // Enable gating: valid code 3 offered while disabled.
    en[0] = 1'b0; code[0] = 3'd3; ivld[0] = 1'b1;
    for (int k = 0; k < 6; k++) step();
    chk("gate_out_zero", 32'(out0), 32'd0);
    chk("gate_count", 32'(cnt0), 32'd9);
    en[0] = 1'b1;
    step();
    chk("gate_accept", 32'(out0), 32'h08);
    ivld[0] = 1'b0;
    for (int k = 0; k < 5; k++) step();

    // Reset two cycles into the hold of code 7.
    code[0] = 3'd7; ivld[0] = 1'b1;
    step();
    ivld[0] = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    chk("rst_out", 32'(out0), 32'd0);
    chk("rst_valid", 32'(ov0), 32'd0);
    chk("rst_count", 32'(cnt0), 32'd0);
    rst_n = 1'b1;
    step();

    // d1: minimum hold, back-to-back codes, count wraps at 8.
    en[0] = 1'b0;
    en[1] = 1'b1; ivld[1] = 1'b1; ordy[1] = 1'b1;
    for (int k = 0; k < 18; k++) begin
      code[1] = 3'($urandom_range(0, 7));
      step();
    end
    chk("wrap_count", 32'(cnt1), 32'd1);
    ivld[1] = 1'b0;
    step();

    // Random traffic on both instances with occasional resets.
    for (int k = 0; k < 600; k++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      for (int i = 0; i < 2; i++) begin
        en[i]   = ($urandom_range(0, 3) != 0);
        ivld[i] = $urandom_range(0, 1) == 1;
        code[i] = 3'($urandom_range(0, 7));
        ordy[i] = ($urandom_range(0, 2) != 0);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
